// File: rtl/jt1943_pal_loader.sv
// jt1943_pal_loader: programs the 1943 palette/priority PROMs (12A, 13A, 14A, 12C)
// from the ROM download stream and reports whether a complete palette has arrived.
// Optional feature macro: JT1943_PAL_CLEAR_EN zeroes all four PROMs after reset
// so the screen stays black until a palette has been downloaded.
module jt1943_pal_loader #(
    parameter logic [21:0] START_ADDR = 22'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    output logic [7:0]  prog_addr,
    output logic [3:0]  prom_din,
    output logic        prom_12a_we,
    output logic        prom_13a_we,
    output logic        prom_14a_we,
    output logic        prom_12c_we,
    output logic        busy,
    output logic        pal_ready,
    output logic        err
);

    localparam logic [10:0] FullCount = 11'd1024;

    typedef enum logic [1:0] {StClear, StIdle, StLoad, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  prog_addr_q, prog_addr_d;
    logic [3:0]  prom_din_q, prom_din_d;
    logic [3:0]  we_q, we_d;   // {12c, 14a, 13a, 12a}
    logic        busy_q, busy_d;
    logic        pal_ready_q, pal_ready_d;
    logic        err_q, err_d;
    logic [10:0] cnt_q, cnt_d;
`ifdef JT1943_PAL_CLEAR_EN
    logic [7:0]  sweep_q, sweep_d;
`endif

    // Offset into the palette window; wraps for addresses below START_ADDR
    logic [21:0] off;
    logic        in_win;
    assign off    = ioctl_addr - START_ADDR;
    assign in_win = off < 22'd1024;

    logic unused_data;
    assign unused_data = ^ioctl_data[7:4];

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        prog_addr_d = prog_addr_q;
        prom_din_d  = prom_din_q;
        we_d        = 4'b0000;
        pal_ready_d = pal_ready_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
`ifdef JT1943_PAL_CLEAR_EN
        sweep_d     = sweep_q;
`endif
        case (state_q)
            StClear: begin
`ifdef JT1943_PAL_CLEAR_EN
                if (downloading) begin
                    // Abort the sweep; the download owns the PROM ports from here
                    state_d     = StLoad;
                    pal_ready_d = 1'b0;
                    err_d       = 1'b0;
                    cnt_d       = '0;
                end else if (&we_q && prog_addr_q == 8'hFF) begin
                    state_d = StIdle;
                end else begin
                    we_d        = 4'b1111;
                    prog_addr_d = sweep_q;
                    prom_din_d  = 4'h0;
                    sweep_d     = sweep_q + 8'd1;
                end
`else
                state_d = StIdle;
`endif
            end
            StIdle, StDone: begin
                if (downloading) begin
                    state_d     = StLoad;
                    pal_ready_d = 1'b0;
                    err_d       = 1'b0;
                    cnt_d       = '0;
                end
            end
            StLoad: begin
                if (ioctl_wr && in_win) begin
                    prog_addr_d = off[7:0];
                    prom_din_d  = ioctl_data[3:0];
                    we_d        = 4'b0001 << off[9:8];
                    if (cnt_q != FullCount) cnt_d = cnt_q + 11'd1;
                end
                // Uses cnt_d so a byte arriving with the falling edge still counts
                if (!downloading) begin
                    state_d     = StDone;
                    pal_ready_d = (cnt_d == FullCount);
                    err_d       = (cnt_d != FullCount);
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StClear) || (state_d == StLoad);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
`ifdef JT1943_PAL_CLEAR_EN
            state_q <= StClear;
            busy_q  <= 1'b1;
            sweep_q <= '0;
`else
            state_q <= StIdle;
            busy_q  <= 1'b0;
`endif
            prog_addr_q <= '0;
            prom_din_q  <= '0;
            we_q        <= '0;
            pal_ready_q <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            prog_addr_q <= prog_addr_d;
            prom_din_q  <= prom_din_d;
            we_q        <= we_d;
            pal_ready_q <= pal_ready_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
`ifdef JT1943_PAL_CLEAR_EN
            sweep_q     <= sweep_d;
`endif
        end
    end

    assign prog_addr   = prog_addr_q;
    assign prom_din    = prom_din_q;
    assign prom_12a_we = we_q[0];
    assign prom_13a_we = we_q[1];
    assign prom_14a_we = we_q[2];
    assign prom_12c_we = we_q[3];
    assign busy        = busy_q;
    assign pal_ready   = pal_ready_q;
    assign err         = err_q;

endmodule

// File: tb/tb_jt1943_pal_loader.sv
// Self-checking bench for jt1943_pal_loader. Follows JT1943_PAL_CLEAR_EN if defined.
module tb_jt1943_pal_loader;

    localparam logic [21:0] START = 22'h14000;

    logic        clk;
    logic        rst_n;
    logic        downloading;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic [7:0]  prog_addr;
    logic [3:0]  prom_din;
    logic        prom_12a_we, prom_13a_we, prom_14a_we, prom_12c_we;
    logic        busy, pal_ready, err;
    logic [3:0]  we;

    assign we = {prom_12c_we, prom_14a_we, prom_13a_we, prom_12a_we};

    jt1943_pal_loader #(.START_ADDR(START)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_data  (ioctl_data),
        .ioctl_wr    (ioctl_wr),
        .prog_addr   (prog_addr),
        .prom_din    (prom_din),
        .prom_12a_we (prom_12a_we),
        .prom_13a_we (prom_13a_we),
        .prom_14a_we (prom_14a_we),
        .prom_12c_we (prom_12c_we),
        .busy        (busy),
        .pal_ready   (pal_ready),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         cnt;
    logic [7:0] last_addr;
    logic [3:0] last_din;
    logic [3:0] exp_mem [4][256];
    logic [3:0] sh_mem  [4][256];

    // Shadow PROMs written by whatever the DUT strobes
    always @(negedge clk) begin
        if (prom_12a_we) sh_mem[0][prog_addr] = prom_din;
        if (prom_13a_we) sh_mem[1][prog_addr] = prom_din;
        if (prom_14a_we) sh_mem[2][prog_addr] = prom_din;
        if (prom_12c_we) sh_mem[3][prog_addr] = prom_din;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One download byte; dl is the level of downloading during that cycle
    task automatic wr_byte(input logic [21:0] a, input logic [7:0] d, input logic dl);
        logic [21:0] off;
        logic [3:0]  exp_we;
        int          prom;
        off    = a - START;
        exp_we = 4'b0000;
        if (off < 22'd1024) begin
            prom           = int'(off) / 256;
            last_addr      = 8'(int'(off) % 256);
            last_din       = d[3:0];
            exp_we[prom]   = 1'b1;
            exp_mem[prom][last_addr] = d[3:0];
            if (cnt < 1024) cnt++;
        end
        ioctl_addr  = a;
        ioctl_data  = d;
        ioctl_wr    = 1'b1;
        downloading = dl;
        tick();
        ioctl_wr = 1'b0;
        chk("byte_we", 32'(we), 32'(exp_we));
        chk("byte_addr", 32'(prog_addr), 32'(last_addr));
        chk("byte_din", 32'(prom_din), 32'(last_din));
    endtask

    task automatic start_session();
        downloading = 1'b1;
        cnt = 0;
        tick();
        chk("entry_busy", 32'(busy), 32'd1);
        chk("entry_ready", 32'(pal_ready), 32'd0);
        chk("entry_err", 32'(err), 32'd0);
        chk("entry_we", 32'(we), 32'd0);
    endtask

    task automatic end_session();
        downloading = 1'b0;
        tick();
        chk("end_ready", 32'(pal_ready), 32'(cnt == 1024));
        chk("end_err", 32'(err), 32'(cnt != 1024));
        chk("end_busy", 32'(busy), 32'd0);
    endtask

    // Random in-window bytes interleaved with gaps and out-of-window bytes
    task automatic random_bytes(input int n);
        int n_in;
        int r;
        n_in = 0;
        while (n_in < n) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                ioctl_wr = 1'b0;
                tick();
                chk("gap_we", 32'(we), 32'd0);
            end else if (r == 1) begin
                wr_byte(START + 22'd1024 + 22'($urandom_range(0, 4095)), 8'($urandom), 1'b1);
            end else if (r == 2) begin
                wr_byte(START - 22'd1 - 22'($urandom_range(0, 4095)), 8'($urandom), 1'b1);
            end else begin
                wr_byte(START + 22'($urandom_range(0, 1023)), 8'($urandom), 1'b1);
                n_in++;
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 256; i++) begin
                sh_mem[p][i]  = 4'h0;
                exp_mem[p][i] = 4'h0;
            end
        rst_n       = 1'b0;
        downloading = 1'b0;
        ioctl_addr  = '0;
        ioctl_data  = '0;
        ioctl_wr    = 1'b0;
        cnt         = 0;
        last_addr   = '0;
        last_din    = '0;
        repeat (3) tick();

        // Reset state
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_addr", 32'(prog_addr), 32'd0);
        chk("rst_din", 32'(prom_din), 32'd0);
        chk("rst_ready", 32'(pal_ready), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
`ifdef JT1943_PAL_CLEAR_EN
        chk("rst_busy", 32'(busy), 32'd1);
`else
        chk("rst_busy", 32'(busy), 32'd0);
`endif

        // Reset release: clear sweep, or straight to idle
        rst_n = 1'b1;
`ifdef JT1943_PAL_CLEAR_EN
        for (int k = 0; k < 256; k++) begin
            tick();
            chk("clr_we", 32'(we), 32'hF);
            chk("clr_addr", 32'(prog_addr), 32'(k));
            chk("clr_din", 32'(prom_din), 32'd0);
            chk("clr_busy", 32'(busy), 32'd1);
        end
        last_addr = 8'hFF;
`endif
        tick();
        chk("idle_we", 32'(we), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(pal_ready), 32'd0);

        // Full load, back-to-back; last byte arrives with the downloading fall
        start_session();
        for (int o = 0; o < 1024; o++)
            wr_byte(START + 22'(o), {4'($urandom), 4'(o % 16)}, (o != 1023));
        chk("full_ready", 32'(pal_ready), 32'd1);
        chk("full_err", 32'(err), 32'd0);
        chk("full_busy", 32'(busy), 32'd0);
        tick();
        chk("hold_we", 32'(we), 32'd0);
        chk("hold_addr", 32'(prog_addr), 32'hFF);
        chk("hold_din", 32'(prom_din), 32'hF);
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 256; i++)
                chk("mem", 32'(sh_mem[p][i]), 32'(exp_mem[p][i]));

        // Window edges, then a short random session
        start_session();
        wr_byte(START - 22'd1, 8'h5A, 1'b1);
        wr_byte(START + 22'h400, 8'hA5, 1'b1);
        random_bytes(1000);
        end_session();

        // Over-long session saturates at a full count
        start_session();
        random_bytes(1030);
        end_session();

        // Reset mid-load
        start_session();
        random_bytes(500);
        rst_n       = 1'b0;
        downloading = 1'b0;
        tick();
        chk("mid_rst_we", 32'(we), 32'd0);
        chk("mid_rst_ready", 32'(pal_ready), 32'd0);
        chk("mid_rst_err", 32'(err), 32'd0);
        last_addr = '0;
        last_din  = '0;
        rst_n = 1'b1;
`ifdef JT1943_PAL_CLEAR_EN
        chk("mid_rst_busy", 32'(busy), 32'd1);
        for (int k = 0; k <= 40; k++) begin
            tick();
            chk("clr2_we", 32'(we), 32'hF);
            chk("clr2_addr", 32'(prog_addr), 32'(k));
        end
        last_addr = 8'd40;
        // Download arrives mid-sweep: sweep stops without a further strobe
        downloading = 1'b1;
        cnt = 0;
        tick();
        chk("abort_we", 32'(we), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        chk("abort_addr", 32'(prog_addr), 32'd40);
`else
        chk("mid_rst_busy", 32'(busy), 32'd0);
        tick();
        start_session();
`endif
        wr_byte(START, 8'($urandom), 1'b1);
        random_bytes(599);
        end_session();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
